// File: rtl/ubs_win_acc_pkg.sv
// Shared definitions for the unary-bitstream window accumulator.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
//
// Contents:
//   winState_t   FSM state encoding shared by the top and the bench-facing docs
//   winTerm()    terminal window-position value, 2^bitWidth-1
package ubs_win_acc_pkg;

  // Two-bit encoding; 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } winState_t;

  // Window position on which the final bit of a window is sampled.
  function automatic int winTerm(input int bitWidth);
    return (1 << bitWidth) - 1;
  endfunction

endpackage

// File: rtl/ubs_win_acc_win_cnt.sv
// Up-counter with enable and synchronous clear, used for window position and ones count.
// Latency: count visible the cycle after an enabled edge.
// Backpressure: none; iEn simply stalls the count, iClr wins over iEn.
//
// Ports:
//   iClk, iRstN  clock and asynchronous active-low reset
//   iEn          increment by one this cycle
//   iClr         synchronous clear to zero (priority over iEn)
//   oCnt         current count, W bits, wraps naturally at 2^W
module win_cnt #(
  parameter int W = 4
) (
  input  logic         iClk,
  input  logic         iRstN,
  input  logic         iEn,
  input  logic         iClr,
  output logic [W-1:0] oCnt
);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oCnt <= '0;
    end else if (iClr) begin
      oCnt <= '0;
    end else if (iEn) begin
      oCnt <= oCnt + W'(1);
    end
  end

endmodule

// File: rtl/ubs_win_acc.sv
// Counts ones of a unary stream over 2^BITWIDTH valid bits and offers the count on oVld/iRdy.
// Latency: oVld rises the cycle after the final valid bit of the window is sampled.
// Backpressure: result is held in HOLD until iRdy; iBitVld=0 stalls the window without counting.
//
// Ports:
//   iClk, iRstN  clock and asynchronous active-low reset
//   iStart       clear and begin a new window (ignored in HOLD unless the result is taken)
//   iClr         synchronous abort back to IDLE, pending result dropped, oCnt kept
//   iBit/iBitVld stream bit and its qualifier
//   iRdy         consumer ready for the result
//   oBusy        high while accumulating
//   oVld/oCnt    result valid and popcount (0..2^BITWIDTH)
module ubs_win_acc
  import ubs_win_acc_pkg::*;
#(
  parameter int BITWIDTH = 4
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iStart,
  input  logic              iClr,
  input  logic              iBit,
  input  logic              iBitVld,
  input  logic              iRdy,
  output logic              oBusy,
  output logic              oVld,
  output logic [BITWIDTH:0] oCnt
);

  localparam logic [BITWIDTH-1:0] TERM = BITWIDTH'(winTerm(BITWIDTH));

  winState_t           state;
  winState_t           nxtState;
  logic [BITWIDTH-1:0] winCnt;
  logic [BITWIDTH:0]   accCnt;

  logic startTaken;   // iStart that actually opens a window this cycle
  logic beat;         // a counted stream bit in ACC
  logic lastBeat;     // the counted bit that closes the window
  logic cntClr;
  logic winEn;
  logic accEn;

  // A start in HOLD is only honoured together with the handshake so a result is never lost.
  // In ACC, iStart and iClr both pre-empt counting, so the bit on that cycle is dropped.
  always_comb begin
    startTaken = iStart && ((state != ST_HOLD) || iRdy);
    beat       = (state == ST_ACC) && iBitVld && !iClr && !iStart;
    lastBeat   = beat && (winCnt == TERM);
    // Clearing on the terminal beat leaves both counters at zero for the next window.
    cntClr     = iClr || startTaken || lastBeat;
    winEn      = beat;
    accEn      = beat && iBit;
  end

  win_cnt #(.W(BITWIDTH)) uWinPos (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iEn   (winEn),
    .iClr  (cntClr),
    .oCnt  (winCnt)
  );

  // One bit wider than the position so an all-ones window (2^BITWIDTH) fits.
  win_cnt #(.W(BITWIDTH + 1)) uOnes (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iEn   (accEn),
    .iClr  (cntClr),
    .oCnt  (accCnt)
  );

  // State register.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state <= ST_IDLE;
    end else begin
      state <= nxtState;
    end
  end

  // Next-state logic: iClr > iStart > normal operation.
  always_comb begin
    nxtState = state;
    if (iClr) begin
      nxtState = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iStart) nxtState = ST_ACC;
        end
        ST_ACC: begin
          // A start here restarts the window and stays in ACC.
          if (lastBeat) nxtState = ST_HOLD;
        end
        ST_HOLD: begin
          // Start with the handshake goes straight back to ACC, no idle bubble.
          if (iRdy) nxtState = iStart ? ST_ACC : ST_IDLE;
        end
        default: nxtState = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from the registered state, so they are glitch-free and one cycle after the cause.
  always_comb begin
    oBusy = (state == ST_ACC);
    oVld  = (state == ST_HOLD);
  end

  // Result register: the final bit is added in directly since the ones counter has not seen it yet.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oCnt <= '0;
    end else if (lastBeat) begin
      oCnt <= accCnt + {{BITWIDTH{1'b0}}, iBit};
    end
  end

endmodule
